tdm_demux: RTL and testbench

//   Receive end of a time-division-multiplexed serial bit stream.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_demux_slot_counter.sv | 52 +++++
 rtl/tdm_demux.sv | 178 +++++++++++++++++
 tb/tb_tdm_demux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : tdm_pkg                                                |
// | Shared constants for the TDM receive demultiplexer: FSM state    |
// | encoding and the default channel count.                          |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package tdm_pkg;

  // Default number of slots (channels) per frame
  localparam int TDM_N_CH_DEFAULT = 4;

  // Frame-alignment FSM encoding
  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_demux_slot_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : slot_counter                                           |
// | Modulo-N_CH slot index counter. clr has priority over load1,     |
// | load1 over inc. Wrap is exact for non-power-of-two N_CH.         |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module slot_counter
  import tdm_pkg::*;
#(
  parameter  int N_CH  = TDM_N_CH_DEFAULT,
  localparam int CNT_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, reload to slot 1, or advance with wrap at N_CH-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = C_ONE;
    end else if (inc) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : slot_counter
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tdm_demux                                              |
// | TDM serial receive demux: locks to the slot-0 sync pulse, routes |
// | each slot bit into a shadow register and publishes a complete    |
// | frame on y with a one-cycle frame_valid pulse.                   |
// | Option  : TDM_FRAME_ERR_EN adds frame_err, a pulse on every      |
// |           misaligned sync seen while locked.                     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH  = TDM_N_CH_DEFAULT,
  localparam int CNT_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [N_CH-1:0]  y,
  output logic [CNT_W-1:0] sel,
  output logic             frame_valid,
  output logic             locked
`ifdef TDM_FRAME_ERR_EN
  ,
  output logic             frame_err
`endif
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_CH - 1);

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [N_CH-2:0] shadow_q;
  logic [N_CH-2:0] shadow_d;
  logic [N_CH-1:0] y_q;
  logic [N_CH-1:0] y_d;
  logic            frame_valid_q;
  logic            frame_valid_d;

  // Control decoded from state and strobe
  logic wr_slot0;    // capture din as slot 0 of a new frame
  logic wr_sel;      // capture din at the current slot index
  logic frame_done;  // last slot of an aligned frame is being sampled
  logic cnt_inc;
  logic cnt_load1;
  logic cnt_clr;
  logic resync;      // sync arrived while locked but not at slot 0

  logic [CNT_W-1:0] sel_w;

  slot_counter #(
    .N_CH (N_CH)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (sel_w)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: first sync acquires lock; lock is only lost on reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (en && sync) state_d = ST_LOCKED;
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_HUNT;
    endcase
  end

  // FSM outputs: per-strobe datapath and counter controls
  always_comb begin
    wr_slot0   = 1'b0;
    wr_sel     = 1'b0;
    frame_done = 1'b0;
    cnt_inc    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;
    resync     = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (en && sync) begin
          wr_slot0  = 1'b1;
          cnt_load1 = 1'b1;
        end else if (en) begin
          cnt_clr = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (en) begin
          if (sync && (sel_w != '0)) begin
            // Sync out of place, including at the last slot: drop the
            // partial frame and restart at slot 1.
            resync    = 1'b1;
            wr_slot0  = 1'b1;
            cnt_load1 = 1'b1;
          end else if (sel_w == C_LAST) begin
            frame_done = 1'b1;
            cnt_inc    = 1'b1;
          end else begin
            wr_sel  = 1'b1;
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: shadow capture and whole-frame publish
  always_comb begin
    shadow_d = shadow_q;
    if (wr_slot0) begin
      shadow_d[0] = din;
    end
    for (int k = 0; k < N_CH - 1; k++) begin
      if (wr_sel && (sel_w == CNT_W'(k))) begin
        shadow_d[k] = din;
      end
    end
    y_d           = frame_done ? {din, shadow_q} : y_q;
    frame_valid_d = frame_done;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
    end
  end

`ifdef TDM_FRAME_ERR_EN
  logic frame_err_q;
  logic frame_err_d;

  // Misaligned-sync pulse, coincident with the resync edge
  always_comb begin
    frame_err_d = resync;
  end

  // Frame error register
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign y           = y_q;
  assign sel         = sel_w;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_tdm_demux                                           |
// | Self-checking bench: a 4-channel and a 3-channel instance driven |
// | from a vector table, then a randomized run on the 4-channel one  |
// | against a behavioural frame model. TDM_FRAME_ERR_EN adds checks  |
// | of frame_err.                                                    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_tdm_demux;

  typedef struct {
    bit       dut;     // 0: N_CH=4 instance, 1: N_CH=3 instance
    bit       rst;
    bit       en;
    bit       sync;
    bit       din;
    bit [3:0] y;
    bit [1:0] sel;
    bit       fv;
    bit       lk;
    bit       fe;
    string    tag;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       rst4 = 1'b0, en4 = 1'b0, sync4 = 1'b0, din4 = 1'b0;
  logic [3:0] y4;
  logic [1:0] sel4;
  logic       fv4, lk4;
  // 3-channel instance
  logic       rst3 = 1'b0, en3 = 1'b0, sync3 = 1'b0, din3 = 1'b0;
  logic [2:0] y3;
  logic [1:0] sel3;
  logic       fv3, lk3;
`ifdef TDM_FRAME_ERR_EN
  logic       fe4, fe3;
`endif

  tdm_demux #(.N_CH(4)) u_dut4 (
    .clk (clk), .rst (rst4), .en (en4), .sync (sync4), .din (din4),
    .y (y4), .sel (sel4), .frame_valid (fv4), .locked (lk4)
`ifdef TDM_FRAME_ERR_EN
    , .frame_err (fe4)
`endif
  );

  tdm_demux #(.N_CH(3)) u_dut3 (
    .clk (clk), .rst (rst3), .en (en3), .sync (sync3), .din (din3),
    .y (y3), .sel (sel3), .frame_valid (fv3), .locked (lk3)
`ifdef TDM_FRAME_ERR_EN
    , .frame_err (fe3)
`endif
  );

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural model of the 4-channel instance for the random phase
  bit       m_lk;
  int       m_sel;
  bit [3:0] m_sh;
  bit [3:0] m_y;
  bit       m_fv;
  bit       m_fe;

  function automatic vec_t mk(bit d, bit r, bit e, bit s, bit di,
                              bit [3:0] ey, bit [1:0] es, bit efv,
                              bit elk, bit efe, string t);
    vec_t v;
    v.dut = d; v.rst = r; v.en = e; v.sync = s; v.din = di;
    v.y = ey; v.sel = es; v.fv = efv; v.lk = elk; v.fe = efe; v.tag = t;
    return v;
  endfunction

  // Drive one vector at the falling edge, queue its expectation, sample after the edge
  task automatic apply(input vec_t v);
    vec_t     e;
    bit [3:0] ay;
    bit [1:0] asel;
    bit       afv, alk, afe, ok;
    @(negedge clk);
    rst4 = 1'b0; en4 = 1'b0; sync4 = 1'b0; din4 = 1'b0;
    rst3 = 1'b0; en3 = 1'b0; sync3 = 1'b0; din3 = 1'b0;
    if (v.dut == 1'b0) begin
      rst4 = v.rst; en4 = v.en; sync4 = v.sync; din4 = v.din;
    end else begin
      rst3 = v.rst; en3 = v.en; sync3 = v.sync; din3 = v.din;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    afe = 1'b0;
    if (e.dut == 1'b0) begin
      ay = y4; asel = sel4; afv = fv4; alk = lk4;
`ifdef TDM_FRAME_ERR_EN
      afe = fe4;
`endif
    end else begin
      ay = {1'b0, y3}; asel = sel3; afv = fv3; alk = lk3;
`ifdef TDM_FRAME_ERR_EN
      afe = fe3;
`endif
    end
    ok = (ay === e.y) && (asel === e.sel) && (afv === e.fv) && (alk === e.lk);
`ifdef TDM_FRAME_ERR_EN
    ok = ok && (afe === e.fe);
`endif
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got y=%b sel=%0d fv=%b locked=%b ferr=%b, want y=%b sel=%0d fv=%b locked=%b ferr=%b",
               e.tag, ay, asel, afv, alk, afe, e.y, e.sel, e.fv, e.lk, e.fe);
    end
  endtask

  // Advance the model by one clock with the given inputs
  task automatic model_step(input bit r, input bit e, input bit s, input bit d);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_lk = 1'b0; m_sel = 0; m_sh = '0; m_y = '0;
    end else if (e) begin
      if (!m_lk) begin
        if (s) begin
          m_sh[0] = d; m_sel = 1; m_lk = 1'b1;
        end
      end else if (s && m_sel != 0) begin
        m_sh[0] = d; m_sel = 1; m_fe = 1'b1;
      end else if (m_sel == 3) begin
        m_y = {d, m_sh[2:0]}; m_fv = 1'b1; m_sel = 0;
      end else begin
        m_sh[m_sel] = d; m_sel = m_sel + 1;
      end
    end
  endtask

  initial begin
    // reset state
    tbl.push_back(mk(0,1,0,0,0, 4'b0000,0,0,0,0, "rst_a"));
    tbl.push_back(mk(0,1,0,0,0, 4'b0000,0,0,0,0, "rst_b"));
    // first frame 1,0,1,1
    tbl.push_back(mk(0,0,1,1,1, 4'b0000,1,0,1,0, "f1_s0"));
    tbl.push_back(mk(0,0,1,0,0, 4'b0000,2,0,1,0, "f1_s1"));
    tbl.push_back(mk(0,0,1,0,1, 4'b0000,3,0,1,0, "f1_s2"));
    tbl.push_back(mk(0,0,1,0,1, 4'b1101,0,1,1,0, "f1_s3"));
    tbl.push_back(mk(0,0,0,0,0, 4'b1101,0,0,1,0, "f1_hold"));
    // en gaps mid-frame; sync and din ignored while en=0
    tbl.push_back(mk(0,0,1,1,1, 4'b1101,1,0,1,0, "gap_s0"));
    tbl.push_back(mk(0,0,1,0,0, 4'b1101,2,0,1,0, "gap_s1"));
    tbl.push_back(mk(0,0,0,1,1, 4'b1101,2,0,1,0, "gap_idle0"));
    tbl.push_back(mk(0,0,0,0,0, 4'b1101,2,0,1,0, "gap_idle1"));
    tbl.push_back(mk(0,0,0,1,1, 4'b1101,2,0,1,0, "gap_idle2"));
    tbl.push_back(mk(0,0,1,0,0, 4'b1101,3,0,1,0, "gap_s2"));
    tbl.push_back(mk(0,0,1,0,1, 4'b1001,0,1,1,0, "gap_s3"));
    // misaligned sync at slot 2, then full frame 0,1,1,0
    tbl.push_back(mk(0,0,1,1,1, 4'b1001,1,0,1,0, "mis2_s0"));
    tbl.push_back(mk(0,0,1,0,0, 4'b1001,2,0,1,0, "mis2_s1"));
    tbl.push_back(mk(0,0,1,1,0, 4'b1001,1,0,1,1, "mis2_sync"));
    tbl.push_back(mk(0,0,1,0,1, 4'b1001,2,0,1,0, "mis2_r1"));
    tbl.push_back(mk(0,0,1,0,1, 4'b1001,3,0,1,0, "mis2_r2"));
    tbl.push_back(mk(0,0,1,0,0, 4'b0110,0,1,1,0, "mis2_r3"));
    // sync at the last slot discards the frame
    tbl.push_back(mk(0,0,1,1,1, 4'b0110,1,0,1,0, "mis3_s0"));
    tbl.push_back(mk(0,0,1,0,1, 4'b0110,2,0,1,0, "mis3_s1"));
    tbl.push_back(mk(0,0,1,0,1, 4'b0110,3,0,1,0, "mis3_s2"));
    tbl.push_back(mk(0,0,1,1,1, 4'b0110,1,0,1,1, "mis3_sync"));
    tbl.push_back(mk(0,0,1,0,0, 4'b0110,2,0,1,0, "mis3_r1"));
    tbl.push_back(mk(0,0,1,0,0, 4'b0110,3,0,1,0, "mis3_r2"));
    tbl.push_back(mk(0,0,1,0,1, 4'b1001,0,1,1,0, "mis3_r3"));
    // reset beats en/sync; no sync -> never locks
    tbl.push_back(mk(0,1,1,1,1, 4'b0000,0,0,0,0, "hunt_rst"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,1,0,bit'(i % 2 == 0), 4'b0000,0,0,0,0, "hunt_nosync"));
    // reset while locked at slot 2
    tbl.push_back(mk(0,0,1,1,1, 4'b0000,1,0,1,0, "lrst_s0"));
    tbl.push_back(mk(0,0,1,0,1, 4'b0000,2,0,1,0, "lrst_s1"));
    tbl.push_back(mk(0,1,1,1,0, 4'b0000,0,0,0,0, "lrst_rst"));
    tbl.push_back(mk(0,0,1,0,1, 4'b0000,0,0,0,0, "lrst_hunt"));
    // 3-channel instance: wrap 2->0, frames 1,1,0 and 0,1,1, misalign
    tbl.push_back(mk(1,1,0,0,0, 4'b0000,0,0,0,0, "n3_rst"));
    tbl.push_back(mk(1,0,1,1,1, 4'b0000,1,0,1,0, "n3_f1_s0"));
    tbl.push_back(mk(1,0,1,0,1, 4'b0000,2,0,1,0, "n3_f1_s1"));
    tbl.push_back(mk(1,0,1,0,0, 4'b0011,0,1,1,0, "n3_f1_s2"));
    tbl.push_back(mk(1,0,1,1,0, 4'b0011,1,0,1,0, "n3_f2_s0"));
    tbl.push_back(mk(1,0,1,0,1, 4'b0011,2,0,1,0, "n3_f2_s1"));
    tbl.push_back(mk(1,0,1,0,1, 4'b0110,0,1,1,0, "n3_f2_s2"));
    tbl.push_back(mk(1,0,1,1,1, 4'b0110,1,0,1,0, "n3_mis_s0"));
    tbl.push_back(mk(1,0,1,1,0, 4'b0110,1,0,1,1, "n3_mis_sync"));
    tbl.push_back(mk(1,0,1,0,0, 4'b0110,2,0,1,0, "n3_mis_s1"));
    tbl.push_back(mk(1,0,1,0,1, 4'b0100,0,1,1,0, "n3_mis_s2"));

    foreach (tbl[i]) apply(tbl[i]);

    // Randomized traffic on the 4-channel instance checked against the model
    begin
      vec_t v;
      model_step(1'b1, 1'b0, 1'b0, 1'b0);
      apply(mk(0,1,0,0,0, m_y, 2'(m_sel), m_fv, m_lk, m_fe, "rnd_rst"));
      for (int i = 0; i < 400; i++) begin
        bit r, e, s, d;
        r = ($urandom_range(0, 99) == 0);
        e = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 5) == 0);
        d = 1'($urandom_range(0, 1));
        model_step(r, e, s, d);
        v = mk(0, r, e, s, d, m_y, 2'(m_sel), m_fv, m_lk, m_fe, "rnd");
        apply(v);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux
`default_nettype wire
